// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller states,
// default operand width and the derived accumulator width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mult_state_e;

    localparam int N_DEF = 4;

    // The accumulator holds an N+1-bit partial sum above the N-bit multiplier.
    function automatic int acc_width(input int n);
        return (2 * n) + 1;
    endfunction

    localparam int ACC_W = acc_width(N_DEF);

endpackage

// File: rtl/mult_bit_cnt.sv
// Counts processed multiplier bits; flags the last bit and never advances past it.
module mult_bit_cnt #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] cnt_r;

    // Bit counter: cleared on load, advanced on each shift, held at N-1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && !last) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: drives the accumulator's Load/Ad/Sh
// strobes and reports Busy/Done through a level St/Done handshake.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N)
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic St,
    input  logic M,
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Busy,
    output logic Done
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CHECK = CHECK;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0] state_r;
    logic [1:0] next_s;
    logic       load_s;
    logic       ad_s;
    logic       sh_s;
    logic       last_s;
    logic       busy_r;
    logic       done_r;

    mult_bit_cnt #(
        .N  (N),
        .CW (CW)
    ) u_bit_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (load_s),
        .inc   (sh_s),
        .last  (last_s)
    );

    // Next-state and strobe decode; strobes are Mealy so the accumulator sees them on the same edge.
    always_comb begin
        next_s = state_r;
        load_s = 1'b0;
        ad_s   = 1'b0;
        sh_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (St) begin
                    load_s = 1'b1;
                    next_s = ST_CHECK;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (M) begin
                    ad_s   = 1'b1;
                    next_s = ST_SHIFT;
                end else begin
                    sh_s   = 1'b1;
                    next_s = last_s ? ST_DONE : ST_CHECK;
                end
            end
            ST_SHIFT: begin
                sh_s   = 1'b1;
                next_s = last_s ? ST_DONE : ST_CHECK;
            end
            ST_DONE: begin
                if (St) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Busy/Done registered from the next state so they track the state exactly.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s == ST_CHECK) || (next_s == ST_SHIFT);
            done_r <= (next_s == ST_DONE);
        end
    end

    // IDLE with St=1 would otherwise request a load while reset is still held.
    assign Load = load_s & Rst_n;
    assign Ad   = ad_s & Rst_n;
    assign Sh   = sh_s & Rst_n;
    assign Busy = busy_r;
    assign Done = done_r;

endmodule
